// File: rtl/hazard_pkg.sv
// Shared decode constants, instruction classes and shadow-stage types for hazard_ctrl.
// MDU classes are only produced by the decoder when HAZARD_MDU_EN is defined.
package hazard_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ANDI  = 6'h0c;
  localparam logic [5:0] OP_ORI   = 6'h0d;
  localparam logic [5:0] OP_LUI   = 6'h0f;
  localparam logic [5:0] OP_LB    = 6'h20;
  localparam logic [5:0] OP_LH    = 6'h21;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SB    = 6'h28;
  localparam logic [5:0] OP_SH    = 6'h29;
  localparam logic [5:0] OP_SW    = 6'h2b;

  localparam logic [5:0] F_JR    = 6'h08;
  localparam logic [5:0] F_MFHI  = 6'h10;
  localparam logic [5:0] F_MTHI  = 6'h11;
  localparam logic [5:0] F_MFLO  = 6'h12;
  localparam logic [5:0] F_MTLO  = 6'h13;
  localparam logic [5:0] F_MULT  = 6'h18;
  localparam logic [5:0] F_MULTU = 6'h19;
  localparam logic [5:0] F_DIV   = 6'h1a;
  localparam logic [5:0] F_DIVU  = 6'h1b;
  localparam logic [5:0] F_ADD   = 6'h20;
  localparam logic [5:0] F_SUB   = 6'h22;
  localparam logic [5:0] F_AND   = 6'h24;
  localparam logic [5:0] F_OR    = 6'h25;
  localparam logic [5:0] F_SLT   = 6'h2a;
  localparam logic [5:0] F_SLTU  = 6'h2b;

  typedef enum logic [3:0] {
    CLS_NOP,
    CLS_CAL_R,
    CLS_CAL_I,
    CLS_LOAD,
    CLS_STORE,
    CLS_BRANCH,
    CLS_JAL,
    CLS_JR,
    CLS_MDU,
    CLS_MF,
    CLS_MT
  } instr_class_e;

  // Tuse: cycles until the operand is consumed, counted from D.
  localparam logic [1:0] TUSE_D = 2'd0;
  localparam logic [1:0] TUSE_E = 2'd1;
  localparam logic [1:0] TUSE_M = 2'd2;

  // Tnew: cycles until the result exists, counted on entry to E.
  localparam logic [1:0] TNEW_LINK = 2'd0;
  localparam logic [1:0] TNEW_ALU  = 2'd1;
  localparam logic [1:0] TNEW_LOAD = 2'd2;

  localparam logic [4:0] REG_RA = 5'd31;

  // Codes are stage indices; a consumer's select is producer index minus its own.
  localparam logic [1:0] FWD_RF = 2'd0;
  localparam logic [1:0] FWD_E  = 2'd1;
  localparam logic [1:0] FWD_M  = 2'd2;
  localparam logic [1:0] FWD_W  = 2'd3;

  typedef struct packed {
    logic       valid;
    logic [4:0] dest;
    logic [1:0] tnew;
    logic [4:0] rs;
    logic [4:0] rt;
    logic       mdu;
  } e_stage_t;

  typedef struct packed {
    logic       valid;
    logic [4:0] dest;
    logic [1:0] tnew;
    logic [4:0] rt;
  } m_stage_t;

  typedef struct packed {
    logic       valid;
    logic [4:0] dest;
    logic [1:0] tnew;
  } w_stage_t;

  function automatic logic [1:0] tnew_dec(input logic [1:0] t);
    return (t == 2'd0) ? 2'd0 : t - 2'd1;
  endfunction

endpackage

// File: rtl/instr_classify.sv
// Combinational decoder: instruction class, source usage/Tuse, destination/Tnew.
// mult/div/mf/mt are recognised only when HAZARD_MDU_EN is defined.
module instr_classify
  import hazard_pkg::*;
(
  input  logic [31:0]  instr_i,
  output instr_class_e class_o,
  output logic [4:0]   rs_o,
  output logic [4:0]   rt_o,
  output logic         rs_used_o,
  output logic         rt_used_o,
  output logic [1:0]   tuse_rs_o,
  output logic [1:0]   tuse_rt_o,
  output logic [4:0]   dest_o,
  output logic [1:0]   tnew_o,
  output logic         is_div_o
);

  logic [5:0] op;
  logic [5:0] funct;
  logic [4:0] rd;
  logic       unused_shamt;

  assign op           = instr_i[31:26];
  assign rs_o         = instr_i[25:21];
  assign rt_o         = instr_i[20:16];
  assign rd           = instr_i[15:11];
  assign funct        = instr_i[5:0];
  assign unused_shamt = ^instr_i[10:6];
  assign is_div_o     = (funct == F_DIV) || (funct == F_DIVU);

  always_comb begin
    class_o = CLS_NOP;
    case (op)
      OP_RTYPE: begin
        case (funct)
          F_ADD, F_SUB, F_AND, F_OR, F_SLT, F_SLTU: class_o = CLS_CAL_R;
          F_JR:                                     class_o = CLS_JR;
`ifdef HAZARD_MDU_EN
          F_MULT, F_MULTU, F_DIV, F_DIVU:           class_o = CLS_MDU;
          F_MFHI, F_MFLO:                           class_o = CLS_MF;
          F_MTHI, F_MTLO:                           class_o = CLS_MT;
`endif
          default:                                  class_o = CLS_NOP;
        endcase
      end
      OP_ADDI, OP_ANDI, OP_ORI, OP_LUI: class_o = CLS_CAL_I;
      OP_LW, OP_LH, OP_LB:              class_o = CLS_LOAD;
      OP_SW, OP_SH, OP_SB:              class_o = CLS_STORE;
      OP_BEQ, OP_BNE:                   class_o = CLS_BRANCH;
      OP_JAL:                           class_o = CLS_JAL;
      default:                          class_o = CLS_NOP;
    endcase
  end

  // A destination of $0 is reported as 0, which downstream means "no producer".
  always_comb begin
    rs_used_o = 1'b0;
    rt_used_o = 1'b0;
    tuse_rs_o = TUSE_E;
    tuse_rt_o = TUSE_E;
    dest_o    = 5'd0;
    tnew_o    = 2'd0;
    case (class_o)
      CLS_CAL_R: begin
        rs_used_o = 1'b1;
        rt_used_o = 1'b1;
        dest_o    = rd;
        tnew_o    = TNEW_ALU;
      end
      CLS_CAL_I: begin
        rs_used_o = 1'b1;
        dest_o    = rt_o;
        tnew_o    = TNEW_ALU;
      end
      CLS_LOAD: begin
        rs_used_o = 1'b1;
        dest_o    = rt_o;
        tnew_o    = TNEW_LOAD;
      end
      CLS_STORE: begin
        rs_used_o = 1'b1;
        rt_used_o = 1'b1;
        tuse_rt_o = TUSE_M;
      end
      CLS_BRANCH: begin
        rs_used_o = 1'b1;
        rt_used_o = 1'b1;
        tuse_rs_o = TUSE_D;
        tuse_rt_o = TUSE_D;
      end
      CLS_JAL: begin
        dest_o = REG_RA;
        tnew_o = TNEW_LINK;
      end
      CLS_JR: begin
        rs_used_o = 1'b1;
        tuse_rs_o = TUSE_D;
      end
      CLS_MDU: begin
        rs_used_o = 1'b1;
        rt_used_o = 1'b1;
      end
      CLS_MF: begin
        dest_o = rd;
        tnew_o = TNEW_ALU;
      end
      CLS_MT: begin
        rs_used_o = 1'b1;
      end
      default: begin
        rs_used_o = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Five-stage MIPS hazard controller: Tuse/Tnew stall, forwarding selects, MDU busy interlock.
// Define HAZARD_MDU_EN to decode mult/div/mf/mt and build the busy counter.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10,
  parameter int CNT_W       = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] instr_d,
  output logic        stall,
  output logic [1:0]  fwd_rs_d,
  output logic [1:0]  fwd_rt_d,
  output logic [1:0]  fwd_rs_e,
  output logic [1:0]  fwd_rt_e,
  output logic        fwd_rt_m,
  output logic        mdu_busy
);

  localparam logic [1:0] SEL_E_FROM_M = FWD_M - FWD_E;
  localparam logic [1:0] SEL_E_FROM_W = FWD_W - FWD_E;
  localparam logic [1:0] SEL_M_FROM_W = FWD_W - FWD_M;

  instr_class_e cls;
  logic [4:0]   rs_raw, rt_raw, src_rs, src_rt, dest;
  logic         rs_used, rt_used, is_div;
  logic [1:0]   tuse_rs, tuse_rt, tnew;
  logic         reg_hazard, mdu_hazard;
  logic [1:0]   rt_m_sel;

  e_stage_t e_q, e_d;
  m_stage_t m_q, m_d;
  w_stage_t w_q, w_d;

  instr_classify u_classify (
    .instr_i   (instr_d),
    .class_o   (cls),
    .rs_o      (rs_raw),
    .rt_o      (rt_raw),
    .rs_used_o (rs_used),
    .rt_used_o (rt_used),
    .tuse_rs_o (tuse_rs),
    .tuse_rt_o (tuse_rt),
    .dest_o    (dest),
    .tnew_o    (tnew),
    .is_div_o  (is_div)
  );

  // Unused sources collapse to $0 so they can neither stall nor forward.
  assign src_rs = rs_used ? rs_raw : 5'd0;
  assign src_rt = rt_used ? rt_raw : 5'd0;

  function automatic logic too_late(input logic [4:0] src, input logic [1:0] tuse,
                                    input logic v, input logic [4:0] d, input logic [1:0] tn);
    return (src != 5'd0) && v && (d == src) && (tn > tuse);
  endfunction

  function automatic logic [1:0] pick_fwd(input logic [4:0] src,
                                          input logic nv, input logic [4:0] nd,
                                          input logic [1:0] nt, input logic [1:0] ncode,
                                          input logic fv, input logic [4:0] fd,
                                          input logic [1:0] ft, input logic [1:0] fcode);
    if (src == 5'd0) return FWD_RF;
    if (nv && nd == src) return (nt == 2'd0) ? ncode : FWD_RF;
    if (fv && fd == src) return (ft == 2'd0) ? fcode : FWD_RF;
    return FWD_RF;
  endfunction

  always_comb begin
    reg_hazard = too_late(src_rs, tuse_rs, e_q.valid, e_q.dest, e_q.tnew)
               | too_late(src_rs, tuse_rs, m_q.valid, m_q.dest, m_q.tnew)
               | too_late(src_rt, tuse_rt, e_q.valid, e_q.dest, e_q.tnew)
               | too_late(src_rt, tuse_rt, m_q.valid, m_q.dest, m_q.tnew);
    stall = reg_hazard | mdu_hazard;
  end

  always_comb begin
    fwd_rs_d = pick_fwd(src_rs, e_q.valid, e_q.dest, e_q.tnew, FWD_E,
                        m_q.valid, m_q.dest, m_q.tnew, FWD_M);
    fwd_rt_d = pick_fwd(src_rt, e_q.valid, e_q.dest, e_q.tnew, FWD_E,
                        m_q.valid, m_q.dest, m_q.tnew, FWD_M);
    fwd_rs_e = pick_fwd(e_q.rs, m_q.valid, m_q.dest, m_q.tnew, SEL_E_FROM_M,
                        w_q.valid, w_q.dest, w_q.tnew, SEL_E_FROM_W);
    fwd_rt_e = pick_fwd(e_q.rt, m_q.valid, m_q.dest, m_q.tnew, SEL_E_FROM_M,
                        w_q.valid, w_q.dest, w_q.tnew, SEL_E_FROM_W);
    rt_m_sel = pick_fwd(m_q.rt, w_q.valid, w_q.dest, w_q.tnew, SEL_M_FROM_W,
                        1'b0, 5'd0, 2'd0, FWD_RF);
    fwd_rt_m = (rt_m_sel != FWD_RF);
  end

  // A stalled D instruction stays put, so E takes a bubble that cannot load the counter.
  always_comb begin
    e_d = '0;
    if (!stall) begin
      e_d.valid = (dest != 5'd0);
      e_d.dest  = dest;
      e_d.tnew  = tnew;
      e_d.rs    = src_rs;
      e_d.rt    = src_rt;
      e_d.mdu   = (cls == CLS_MDU);
    end
    m_d.valid = e_q.valid;
    m_d.dest  = e_q.dest;
    m_d.tnew  = tnew_dec(e_q.tnew);
    m_d.rt    = e_q.rt;
    w_d.valid = m_q.valid;
    w_d.dest  = m_q.dest;
    w_d.tnew  = 2'd0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      e_q <= '0;
      m_q <= '0;
      w_q <= '0;
    end else begin
      e_q <= e_d;
      m_q <= m_d;
      w_q <= w_d;
    end
  end

`ifdef HAZARD_MDU_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (e_d.mdu) begin
      cnt_d = is_div ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign mdu_busy   = (cnt_q != '0) | e_q.mdu;
  assign mdu_hazard = mdu_busy & ((cls == CLS_MDU) | (cls == CLS_MF) | (cls == CLS_MT));
`else
  logic unused_mdu;

  assign unused_mdu = ^{is_div, e_q.mdu};
  assign mdu_busy   = 1'b0;
  assign mdu_hazard = 1'b0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed self-checking bench for hazard_ctrl; MDU expectations follow HAZARD_MDU_EN.
module tb_hazard_ctrl;

  logic        clk;
  logic        reset;
  logic [31:0] instr_d;
  logic        stall;
  logic [1:0]  fwd_rs_d, fwd_rt_d, fwd_rs_e, fwd_rt_e;
  logic        fwd_rt_m;
  logic        mdu_busy;

  int total = 0;
  int bad   = 0;

  localparam logic [31:0] NOP = 32'h0000_0000;

  hazard_ctrl #(
    .MULT_CYCLES (5),
    .DIV_CYCLES  (10),
    .CNT_W       (4)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .instr_d  (instr_d),
    .stall    (stall),
    .fwd_rs_d (fwd_rs_d),
    .fwd_rt_d (fwd_rt_d),
    .fwd_rs_e (fwd_rs_e),
    .fwd_rt_e (fwd_rt_e),
    .fwd_rt_m (fwd_rt_m),
    .mdu_busy (mdu_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] rtype(input logic [4:0] rs, input logic [4:0] rt,
                                        input logic [4:0] rd, input logic [5:0] funct);
    return {6'h00, rs, rt, rd, 5'd0, funct};
  endfunction

  function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  // The new word sits in D from just after an edge; outputs are sampled at the falling edge.
  task automatic applyStimulus(input logic [31:0] w);
    @(posedge clk);
    #1;
    instr_d = w;
    @(negedge clk);
  endtask

  task automatic checkOutput(input string tag, input logic [1:0] obs, input logic [1:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic drain();
    repeat (3) applyStimulus(NOP);
  endtask

  logic [31:0] lw8, add988, beq80, add5, sw5, jal0, jr31, addi0, beq00;
  logic [31:0] lw0, add300, add7, beq77, div12, mflo3;

  initial begin
    lw8    = itype(6'h23, 5'd0, 5'd8, 16'd0);
    add988 = rtype(5'd8, 5'd8, 5'd9, 6'h20);
    beq80  = itype(6'h04, 5'd8, 5'd0, 16'd4);
    add5   = rtype(5'd1, 5'd2, 5'd5, 6'h20);
    sw5    = itype(6'h2b, 5'd0, 5'd5, 16'd0);
    jal0   = {6'h03, 26'd0};
    jr31   = rtype(5'd31, 5'd0, 5'd0, 6'h08);
    addi0  = itype(6'h08, 5'd1, 5'd0, 16'd5);
    beq00  = itype(6'h04, 5'd0, 5'd0, 16'd4);
    lw0    = itype(6'h23, 5'd0, 5'd0, 16'd0);
    add300 = rtype(5'd0, 5'd0, 5'd3, 6'h20);
    add7   = rtype(5'd1, 5'd2, 5'd7, 6'h20);
    beq77  = itype(6'h04, 5'd7, 5'd7, 16'd4);
    div12  = rtype(5'd1, 5'd2, 5'd0, 6'h1a);
    mflo3  = rtype(5'd0, 5'd0, 5'd3, 6'h12);

    reset   = 1'b1;
    instr_d = add988;
    #12;
    checkOutput("rst_stall", stall, 2'd0);
    checkOutput("rst_fwd_rs_d", fwd_rs_d, 2'd0);
    checkOutput("rst_fwd_rs_e", fwd_rs_e, 2'd0);
    checkOutput("rst_fwd_rt_m", fwd_rt_m, 2'd0);
    checkOutput("rst_mdu_busy", mdu_busy, 2'd0);
    instr_d = NOP;
    @(negedge clk);
    reset = 1'b0;
    $display("[TB] reset released");

    applyStimulus(lw8);
    checkOutput("lu_lw_in_d", stall, 2'd0);
    applyStimulus(add988);
    checkOutput("lu_stall", stall, 2'd1);
    applyStimulus(add988);
    checkOutput("lu_release", stall, 2'd0);
    applyStimulus(NOP);
    checkOutput("lu_fwd_rs_e", fwd_rs_e, 2'd2);
    checkOutput("lu_fwd_rt_e", fwd_rt_e, 2'd2);
    drain();

    applyStimulus(lw8);
    applyStimulus(beq80);
    checkOutput("lb_stall1", stall, 2'd1);
    applyStimulus(beq80);
    checkOutput("lb_stall2", stall, 2'd1);
    applyStimulus(beq80);
    checkOutput("lb_release", stall, 2'd0);
    checkOutput("lb_fwd_rs_d", fwd_rs_d, 2'd0);
    drain();

    applyStimulus(add5);
    applyStimulus(sw5);
    checkOutput("st_no_stall", stall, 2'd0);
    applyStimulus(NOP);
    checkOutput("st_fwd_rt_e_m", fwd_rt_e, 2'd1);
    checkOutput("st_fwd_rs_e", fwd_rs_e, 2'd0);
    applyStimulus(NOP);
    checkOutput("st_fwd_rt_m", fwd_rt_m, 2'd1);
    drain();

    applyStimulus(add5);
    applyStimulus(NOP);
    applyStimulus(sw5);
    checkOutput("st_gap_no_stall", stall, 2'd0);
    applyStimulus(NOP);
    checkOutput("st_gap_fwd_rt_e_w", fwd_rt_e, 2'd2);
    drain();

    applyStimulus(jal0);
    applyStimulus(jr31);
    checkOutput("jal_no_stall", stall, 2'd0);
    checkOutput("jal_fwd_rs_d", fwd_rs_d, 2'd1);
    applyStimulus(NOP);
    checkOutput("jal_fwd_rs_e", fwd_rs_e, 2'd1);
    drain();

    applyStimulus(addi0);
    applyStimulus(beq00);
    checkOutput("r0_alu_stall", stall, 2'd0);
    checkOutput("r0_alu_fwd_rs_d", fwd_rs_d, 2'd0);
    applyStimulus(lw0);
    applyStimulus(add300);
    checkOutput("r0_load_stall", stall, 2'd0);
    applyStimulus(NOP);
    checkOutput("r0_fwd_rs_e", fwd_rs_e, 2'd0);
    drain();

    applyStimulus(add7);
    applyStimulus(beq77);
    checkOutput("br_alu_stall", stall, 2'd1);
    applyStimulus(beq77);
    checkOutput("br_alu_release", stall, 2'd0);
    checkOutput("br_fwd_rs_d_m", fwd_rs_d, 2'd2);
    checkOutput("br_fwd_rt_d_m", fwd_rt_d, 2'd2);
    drain();

    applyStimulus(div12);
    checkOutput("mdu_idle", mdu_busy, 2'd0);
`ifdef HAZARD_MDU_EN
    for (int i = 0; i < 10; i++) begin
      applyStimulus(mflo3);
      checkOutput($sformatf("mdu_stall_%0d", i), stall, 2'd1);
      checkOutput($sformatf("mdu_busy_%0d", i), mdu_busy, 2'd1);
    end
    applyStimulus(mflo3);
    checkOutput("mdu_stall_end", stall, 2'd0);
    checkOutput("mdu_busy_end", mdu_busy, 2'd0);
`else
    applyStimulus(mflo3);
    checkOutput("mdu_off_stall", stall, 2'd0);
    checkOutput("mdu_off_busy", mdu_busy, 2'd0);
`endif
    drain();

    applyStimulus(lw8);
    applyStimulus(add988);
    checkOutput("rm_stall_before", stall, 2'd1);
    #1;
    reset = 1'b1;
    #1;
    checkOutput("rm_stall_async", stall, 2'd0);
    checkOutput("rm_fwd_rs_e_async", fwd_rs_e, 2'd0);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    applyStimulus(add988);
    checkOutput("rm_post_stall", stall, 2'd0);
    checkOutput("rm_post_fwd_rs_d", fwd_rs_d, 2'd0);
    checkOutput("rm_post_fwd_rt_d", fwd_rt_d, 2'd0);
    checkOutput("rm_post_fwd_rs_e", fwd_rs_e, 2'd0);
    checkOutput("rm_post_fwd_rt_e", fwd_rt_e, 2'd0);
    checkOutput("rm_post_fwd_rt_m", fwd_rt_m, 2'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline hazard controller for the five-stage MIPS core (F/D/E/M/W). It classifies the D-stage instruction, compares its register source-use time (Tuse) against the result-ready time (Tnew) of instructions in flight, and drives the pipeline controls:
- D-stage stall
- forwarding selects for D, E and M
- a multiply/divide busy interlock

It keeps its own shadow pipeline of in-flight producers, so the datapath only hands it the D-stage instruction word.

## Interface
Parameters:
- MULT_CYCLES, 5, busy cycles charged for mult/multu
- DIV_CYCLES, 10, busy cycles charged for div/divu
- CNT_W, 4, width of the busy counter; must hold max(MULT_CYCLES, DIV_CYCLES)

Ports:
- clk  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-high
- instr_d  in  32  instruction currently in D
- stall  out  1  hold F/D, insert bubble into E
- fwd_rs_d, fwd_rt_d  out  2  D-stage compare operands: 0 regfile, 1 E (PC+8), 2 M
- fwd_rs_e, fwd_rt_e  out  2  E-stage ALU operands: 0 pipe reg, 1 M, 2 W
- fwd_rt_m  out  1  M-stage store data: 0 pipe reg, 1 W
- mdu_busy  out  1  busy counter non-zero or MDU start in E

## Operation
- **Classes decoded from instr_d:**
  - cal_r: add, sub, and, or, slt, sltu
  - cal_i: ori, lui, addi, andi
  - load: lw, lh, lb
  - store: sw, sh, sb
  - branch: beq, bne
  - jal, jr
  - mdu: mult, multu, div, divu
  - mf: mfhi, mflo
  - mt: mthi, mtlo
  - Anything else is a nop: no sources, no destination.
- **Tuse:**
  - 0: rs/rt of branch; rs of jr
  - 1: rs/rt of cal_r and mdu; rs of cal_i, load, store and mt
  - 2: rt of store
  - Unused sources never stall.
- **Destination and Tnew on entry to E:**
  - cal_r → rd, 1
  - cal_i → rt, 1
  - load → rt, 2
  - mf → rd, 1
  - jal → 31, 0
  - Destination 0 is treated as no destination.
- **Shadow stages E, M, W:** each holds {valid, dest[4:0], tnew[1:0]}; E also holds rs/rt, M also holds rt.
- **Advance every cycle:**
  - E ← stall ? bubble : decode(instr_d)
  - M ← E with tnew decremented, saturating at 0
  - W ← M with tnew forced to 0
- **Stall:** asserted when, for a used source s with s≠0, stage X∈{E,M} is valid, dest_X==s and tnew_X > Tuse(s).
- **Forwarding:**
  - Nearest valid stage with a matching destination and tnew==0 wins: E before M before W.
  - If the nearest match has tnew>0, the select stays 0; the stall covers it.
  - Source 0 always selects 0.
- **MDU interlock:**
  - When an mdu instruction advances into E, the busy counter loads MULT_CYCLES or DIV_CYCLES.
  - Counter decrements each cycle until 0.
  - Stall whenever an mdu, mf or mt instruction is in D and mdu_busy=1.
- **Simultaneous events:** the stall is the OR of the register hazard and the MDU hazard; a bubble never loads the counter.

## Timing
- All outputs are combinational from instr_d and the shadow/counter registers; zero-cycle latency.
- Shadow regs and counter update on the rising clk edge.
- **Reset:** all shadow stages invalid, counter 0. As a result stall=0, all fwd selects=0, mdu_busy=0 while reset is held.
- **Reset mid-operation:** in-flight state is discarded immediately; the first post-reset instruction sees no hazards.
- **Sustained stall:** E receives a bubble every cycle while stall=1. The producer drains M→W, and stall drops the cycle its tnew falls to ≤ Tuse.
- **Counter:** reaches 0 exactly N cycles after the load edge. mdu_busy=1 during the cycle the mdu instruction sits in E and for the following N−1 cycles.

## Configuration
- **HAZARD_MDU_EN defined:** mdu/mf/mt classes are decoded, the busy counter is present and mdu_busy is driven as above.
- **HAZARD_MDU_EN undefined:** mdu, mf and mt decode as nop, no counter is synthesised, and mdu_busy is tied to 0.

## Structure
- Package hazard_pkg holds:
  - opcode/funct localparams
  - the instruction class enum
  - Tuse/Tnew constants
  - forward-select codes (FWD_RF, FWD_E, FWD_M, FWD_W)
- Sub-module instr_classify, combinational, produces class, rs/rt used flags, Tuse pair, dest and Tnew from a 32-bit word. It is instantiated once, on instr_d.
- Shadow stages and the counter live in hazard_ctrl.

## Test plan
- **Load-use:** lw $8,0($0) then add $9,$8,$8 → stall=1 for 1 cycle; on release fwd_rs_e=fwd_rt_e=2 (W).
- **Load-branch:** lw $8 then beq $8,$0 → stall=1 for 2 cycles; then fwd_rs_d=0 (W data via regfile).
- **Store-data:** add $5,... then sw $5,0($0) → no stall, fwd_rt_e=1; with one nop between them → fwd_rt_e=2.
- **jal forwarding:** jal then jr $31 in D → no stall, fwd_rs_d=1; writes to $0 never stall or forward.
- **MDU:** div $1,$2 then mflo $3 → mdu_busy high for 10 cycles, stall held until the counter hits 0. With HAZARD_MDU_EN undefined: no stall, mdu_busy=0.
- **Reset mid-operation:** assert reset while a lw is in E with a dependent add in D → stall drops asynchronously; after release no stall and all selects are 0.
